// File: rtl/lpif_pkg.sv
// Shared types for the LPIF transmit path: PHY link-state encodings and arbiter FSM states.
// No logic; imported by the arbiter and its output stage.
// Lane count default lives here so sub-blocks agree with the top.
package lpif_pkg;

    localparam int LPIF_LANES = 8;

    typedef enum logic [3:0] {
        LS_RESET   = 4'h0,
        LS_ACTIVE  = 4'h1,
        LS_RETRAIN = 4'h3,
        LS_L1      = 4'h4,
        LS_L2      = 4'h5,
        LS_DISABLE = 4'hC,
        LS_LINKERR = 4'hE
    } lpif_state_e;

    typedef enum logic [2:0] {
        IDLE,
        TLP,
        DLLP,
        STALL,
        FLUSH
    } arb_state_e;

endpackage

// File: rtl/lpif_tx_hold_reg.sv
// Single-register LPIF output stage holding data, byte valids and packet markers.
// Latency: load -> irdy on the next cycle.
// Backpressure: contents frozen while irdy && !trdy; reloads when empty or draining (no bubbles).
module lpif_tx_hold_reg
    import lpif_pkg::*;
#(
    parameter int LANES = LPIF_LANES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [LANES-1:0][7:0] ld_data,
    input  logic [LANES-1:0]      ld_valid,
    input  logic [LANES-1:0]      ld_tlp_start,
    input  logic [LANES-1:0]      ld_tlp_end,
    input  logic [LANES-1:0]      ld_dllp_start,
    input  logic [LANES-1:0]      ld_dllp_end,
    input  logic                  trdy,
    output logic                  can_load,
    output logic [LANES-1:0][7:0] data,
    output logic [LANES-1:0]      valid,
    output logic                  irdy,
    output logic [LANES-1:0]      tlp_start,
    output logic [LANES-1:0]      tlp_end,
    output logic [LANES-1:0]      dllp_start,
    output logic [LANES-1:0]      dllp_end
);

    assign can_load = !irdy || trdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            irdy       <= 1'b0;
            data       <= '0;
            valid      <= '0;
            tlp_start  <= '0;
            tlp_end    <= '0;
            dllp_start <= '0;
            dllp_end   <= '0;
        end else if (can_load) begin
            // An emptied stage shows all-zero lanes rather than a stale beat.
            irdy       <= load;
            data       <= load ? ld_data       : '0;
            valid      <= load ? ld_valid      : '0;
            tlp_start  <= load ? ld_tlp_start  : '0;
            tlp_end    <= load ? ld_tlp_end    : '0;
            dllp_start <= load ? ld_dllp_start : '0;
            dllp_end   <= load ? ld_dllp_end   : '0;
        end
    end

endmodule

// File: rtl/lpif_tx_arbiter.sv
// Packet-granular arbiter sharing the LPIF tx datapath between a TLP and a DLLP source.
// Latency: source accept -> irdy one cycle later through a single output register.
// Backpressure: source ready only when granted, stage free (!irdy || trdy) and link ACTIVE.
module lpif_tx_arbiter
    import lpif_pkg::*;
#(
    parameter int          LANES      = LPIF_LANES,
    parameter int          STARVE_MAX = 4,
    parameter logic [3:0]  ST_ACTIVE  = LS_ACTIVE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tlp_valid,
    output logic                  tlp_ready,
    input  logic [LANES-1:0][7:0] tlp_data,
    input  logic [LANES-1:0]      tlp_bvalid,
    input  logic                  tlp_sop,
    input  logic                  tlp_eop,
    input  logic                  dllp_valid,
    output logic                  dllp_ready,
    input  logic [LANES-1:0][7:0] dllp_data,
    input  logic [LANES-1:0]      dllp_bvalid,
    input  logic                  dllp_sop,
    input  logic                  dllp_eop,
    output logic [LANES-1:0][7:0] data,
    output logic [LANES-1:0]      valid,
    output logic                  irdy,
    input  logic                  trdy,
    output logic [LANES-1:0]      tlp_start,
    output logic [LANES-1:0]      tlp_end,
    output logic [LANES-1:0]      dllp_start,
    output logic [LANES-1:0]      dllp_end,
    input  logic [3:0]            state_sts,
    input  logic                  stall_req,
    output logic                  stall_ack,
    output logic [7:0]            abort_cnt
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    function automatic logic [LANES-1:0] lsb_hot(input logic [LANES-1:0] v);
        return v & (~v + LANES'(1));
    endfunction

    function automatic logic [LANES-1:0] msb_hot(input logic [LANES-1:0] v);
        logic [LANES-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            if (v[i]) r = LANES'(1) << i;
        end
        return r;
    endfunction

    arb_state_e  st, st_n;
    logic [3:0]  starve, starve_n;
    logic        flush_tlp, flush_tlp_n;
    logic        tlp_rdy, dllp_rdy;
    logic        tlp_fwd, dllp_fwd;
    logic        abort_inc;
    logic        can_load;
    logic        link_up;
    logic        force_tlp;
    logic        tlp_send, dllp_send, load;
    logic        stall_ack_n;

    assign link_up   = (state_sts == ST_ACTIVE);
    assign force_tlp = tlp_valid && tlp_sop && (starve == STARVE_LIM);

    always_comb begin
        st_n        = st;
        starve_n    = starve;
        flush_tlp_n = flush_tlp;
        tlp_rdy     = 1'b0;
        dllp_rdy    = 1'b0;
        tlp_fwd     = 1'b0;
        dllp_fwd    = 1'b0;
        abort_inc   = 1'b0;
        case (st)
            IDLE: begin
                if (stall_req) begin
                    st_n = STALL;
                end else if (link_up) begin
                    if (dllp_valid && dllp_sop && !force_tlp) begin
                        dllp_fwd = 1'b1;
                        dllp_rdy = can_load;
                        if (can_load) begin
                            if (!dllp_eop) st_n = DLLP;
                            if (tlp_valid && starve != STARVE_LIM) starve_n = starve + 4'd1;
                        end
                    end else if (tlp_valid && tlp_sop) begin
                        tlp_fwd = 1'b1;
                        tlp_rdy = can_load;
                        if (can_load) begin
                            if (!tlp_eop) st_n = TLP;
                            starve_n = '0;
                        end
                    end else begin
                        // Mid-packet beats with no owner are protocol errors; sink them.
                        tlp_rdy  = tlp_valid;
                        dllp_rdy = !tlp_valid && dllp_valid;
                    end
                end
            end
            TLP: begin
                if (!link_up) begin
                    st_n        = FLUSH;
                    flush_tlp_n = 1'b1;
                end else begin
                    tlp_fwd = 1'b1;
                    tlp_rdy = can_load;
                    if (tlp_valid && can_load && tlp_eop) st_n = IDLE;
                end
            end
            DLLP: begin
                if (!link_up) begin
                    st_n        = FLUSH;
                    flush_tlp_n = 1'b0;
                end else begin
                    dllp_fwd = 1'b1;
                    dllp_rdy = can_load;
                    if (dllp_valid && can_load && dllp_eop) st_n = IDLE;
                end
            end
            STALL: begin
                if (!stall_req) st_n = IDLE;
            end
            FLUSH: begin
                if (flush_tlp) begin
                    tlp_rdy = 1'b1;
                    if (tlp_valid && tlp_eop) begin
                        st_n      = IDLE;
                        abort_inc = 1'b1;
                    end
                end else begin
                    dllp_rdy = 1'b1;
                    if (dllp_valid && dllp_eop) begin
                        st_n      = IDLE;
                        abort_inc = 1'b1;
                    end
                end
            end
            default: st_n = IDLE;
        endcase
    end

    assign tlp_send  = tlp_fwd && tlp_valid && tlp_rdy;
    assign dllp_send = dllp_fwd && dllp_valid && dllp_rdy;
    assign load      = tlp_send || dllp_send;

    assign tlp_ready  = tlp_rdy && !reset;
    assign dllp_ready = dllp_rdy && !reset;

    // Ack is raised on the same edge the last beat leaves the stage.
    assign stall_ack_n = stall_req && (st_n == STALL) && can_load && !load;

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= IDLE;
            starve    <= '0;
            flush_tlp <= 1'b0;
            stall_ack <= 1'b0;
            abort_cnt <= '0;
        end else begin
            st        <= st_n;
            starve    <= starve_n;
            flush_tlp <= flush_tlp_n;
            stall_ack <= stall_ack_n;
            if (abort_inc && abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 8'd1;
        end
    end

    lpif_tx_hold_reg #(.LANES(LANES)) u_hold (
        .clk           (clk),
        .reset         (reset),
        .load          (load),
        .ld_data       (tlp_send ? tlp_data : dllp_data),
        .ld_valid      (tlp_send ? tlp_bvalid : dllp_bvalid),
        .ld_tlp_start  ((tlp_send && tlp_sop)   ? lsb_hot(tlp_bvalid)  : '0),
        .ld_tlp_end    ((tlp_send && tlp_eop)   ? msb_hot(tlp_bvalid)  : '0),
        .ld_dllp_start ((dllp_send && dllp_sop) ? lsb_hot(dllp_bvalid) : '0),
        .ld_dllp_end   ((dllp_send && dllp_eop) ? msb_hot(dllp_bvalid) : '0),
        .trdy          (trdy),
        .can_load      (can_load),
        .data          (data),
        .valid         (valid),
        .irdy          (irdy),
        .tlp_start     (tlp_start),
        .tlp_end       (tlp_end),
        .dllp_start    (dllp_start),
        .dllp_end      (dllp_end)
    );

    a_one_ready: assert property (@(posedge clk) disable iff (reset) !(tlp_ready && dllp_ready));
    a_sop_in_idle: assert property (@(posedge clk) disable iff (reset)
        !(st == IDLE && link_up && !stall_req &&
          ((tlp_valid && !tlp_sop) || (dllp_valid && !dllp_sop))));

endmodule

// File: tb/tb_lpif_tx_arbiter.sv
// Directed bench for lpif_tx_arbiter: queue-fed sources, logged LPIF beats, hand-computed expectations.
module tb_lpif_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        tlp_valid, tlp_ready, tlp_sop, tlp_eop;
    logic [63:0] tlp_data;
    logic [7:0]  tlp_bvalid;
    logic        dllp_valid, dllp_ready, dllp_sop, dllp_eop;
    logic [63:0] dllp_data;
    logic [7:0]  dllp_bvalid;
    logic [63:0] data;
    logic [7:0]  valid, tlp_start, tlp_end, dllp_start, dllp_end;
    logic        irdy, trdy;
    logic [3:0]  state_sts;
    logic        stall_req, stall_ack;
    logic [7:0]  abort_cnt;

    always #5 clk = ~clk;

    lpif_tx_arbiter #(.LANES(8), .STARVE_MAX(4), .ST_ACTIVE(4'h1)) dut (
        .clk(clk), .reset(reset),
        .tlp_valid(tlp_valid), .tlp_ready(tlp_ready), .tlp_data(tlp_data),
        .tlp_bvalid(tlp_bvalid), .tlp_sop(tlp_sop), .tlp_eop(tlp_eop),
        .dllp_valid(dllp_valid), .dllp_ready(dllp_ready), .dllp_data(dllp_data),
        .dllp_bvalid(dllp_bvalid), .dllp_sop(dllp_sop), .dllp_eop(dllp_eop),
        .data(data), .valid(valid), .irdy(irdy), .trdy(trdy),
        .tlp_start(tlp_start), .tlp_end(tlp_end), .dllp_start(dllp_start), .dllp_end(dllp_end),
        .state_sts(state_sts), .stall_req(stall_req), .stall_ack(stall_ack), .abort_cnt(abort_cnt)
    );

    typedef struct { logic [63:0] d; logic [7:0] bv; logic sop; logic eop; } beat_t;
    typedef struct { logic [63:0] d; logic [7:0] v; logic [7:0] ts; logic [7:0] te;
                     logic [7:0] ds; logic [7:0] de; int cyc; } obs_t;

    beat_t      tlp_q[$];
    beat_t      dllp_q[$];
    obs_t       log_q[$];
    logic [7:0] exp_ids[$];
    int n_chk = 0, n_pass = 0, n_fail = 0, cyc_n = 0;

    function automatic logic [7:0] mk_id(input bit is_tlp, input int pkt, input int beat);
        return {is_tlp, 4'(pkt), 3'(beat)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_heads();
        if (tlp_q.size() != 0) begin
            tlp_valid = 1'b1; tlp_data = tlp_q[0].d; tlp_bvalid = tlp_q[0].bv;
            tlp_sop = tlp_q[0].sop; tlp_eop = tlp_q[0].eop;
        end else begin
            tlp_valid = 1'b0; tlp_data = '0; tlp_bvalid = '0; tlp_sop = 1'b0; tlp_eop = 1'b0;
        end
        if (dllp_q.size() != 0) begin
            dllp_valid = 1'b1; dllp_data = dllp_q[0].d; dllp_bvalid = dllp_q[0].bv;
            dllp_sop = dllp_q[0].sop; dllp_eop = dllp_q[0].eop;
        end else begin
            dllp_valid = 1'b0; dllp_data = '0; dllp_bvalid = '0; dllp_sop = 1'b0; dllp_eop = 1'b0;
        end
    endtask

    task automatic push_pkt(input bit is_tlp, input int pkt, input int nb,
                            input logic [7:0] bv_first, input logic [7:0] bv_last);
        beat_t b;
        for (int i = 0; i < nb; i++) begin
            b.d   = {8{mk_id(is_tlp, pkt, i)}};
            b.bv  = (i == 0) ? bv_first : (i == nb - 1) ? bv_last : 8'hFF;
            b.sop = (i == 0);
            b.eop = (i == nb - 1);
            if (is_tlp) tlp_q.push_back(b);
            else        dllp_q.push_back(b);
        end
        drive_heads();
    endtask

    // One clock: sample handshakes at the falling edge, retire accepted beats after the rising edge.
    task automatic cyc();
        bit    t_acc, d_acc;
        obs_t  o;
        beat_t dummy;
        @(negedge clk);
        t_acc = tlp_valid && tlp_ready;
        d_acc = dllp_valid && dllp_ready;
        if (irdy && trdy) begin
            o.d = data; o.v = valid; o.ts = tlp_start; o.te = tlp_end;
            o.ds = dllp_start; o.de = dllp_end; o.cyc = cyc_n;
            log_q.push_back(o);
        end
        @(posedge clk);
        #1;
        cyc_n++;
        if (t_acc) dummy = tlp_q.pop_front();
        if (d_acc) dummy = dllp_q.pop_front();
        drive_heads();
        #1;
    endtask

    task automatic drain(input string tag);
        int i = 0;
        while ((tlp_q.size() != 0 || dllp_q.size() != 0 || irdy) && i < 100) begin
            cyc();
            i++;
        end
        cyc();
        chk({tag, "_drain"}, 64'(tlp_q.size() == 0 && dllp_q.size() == 0 && !irdy), 64'd1);
    endtask

    task automatic chk_log(input string tag);
        chk({tag, "_count"}, 64'(log_q.size()), 64'(exp_ids.size()));
        for (int i = 0; i < exp_ids.size(); i++)
            chk($sformatf("%s_id%0d", tag, i), 64'(log_q[i].d[7:0]), 64'(exp_ids[i]));
    endtask

    task automatic new_test();
        log_q.delete();
        exp_ids.delete();
    endtask

    initial begin
        reset = 1'b1; trdy = 1'b1; state_sts = 4'h1; stall_req = 1'b0;
        drive_heads();
        repeat (2) cyc();
        chk("rst_irdy",      64'(irdy),      64'd0);
        chk("rst_valid",     64'(valid),     64'd0);
        chk("rst_data",      data,           64'd0);
        chk("rst_tlp_start", 64'(tlp_start), 64'd0);
        chk("rst_stall_ack", 64'(stall_ack), 64'd0);
        chk("rst_abort_cnt", 64'(abort_cnt), 64'd0);
        reset = 1'b0;
        cyc();

        // 1: back-to-back 3-beat TLPs at full rate
        new_test();
        push_pkt(1'b1, 1, 3, 8'hFF, 8'h3F);
        push_pkt(1'b1, 2, 3, 8'hFF, 8'h3F);
        drain("t1");
        for (int p = 1; p <= 2; p++)
            for (int b = 0; b < 3; b++) exp_ids.push_back(mk_id(1'b1, p, b));
        chk_log("t1");
        chk("t1_start0",   64'(log_q[0].ts), 64'h01);
        chk("t1_start1",   64'(log_q[1].ts), 64'h00);
        chk("t1_end2",     64'(log_q[2].te), 64'h20);
        chk("t1_start3",   64'(log_q[3].ts), 64'h01);
        chk("t1_end5",     64'(log_q[5].te), 64'h20);
        chk("t1_no_dllp",  64'(log_q[0].ds), 64'h00);
        chk("t1_no_gaps",  64'(log_q[5].cyc - log_q[0].cyc), 64'd5);

        // 2: starvation limit forces the waiting TLP in after 4 DLLPs
        new_test();
        push_pkt(1'b1, 3, 2, 8'hFF, 8'hFF);
        for (int p = 0; p < 7; p++) push_pkt(1'b0, p, 1, 8'hFF, 8'hFF);
        drain("t2");
        for (int p = 0; p < 4; p++) exp_ids.push_back(mk_id(1'b0, p, 0));
        exp_ids.push_back(mk_id(1'b1, 3, 0));
        exp_ids.push_back(mk_id(1'b1, 3, 1));
        for (int p = 4; p < 7; p++) exp_ids.push_back(mk_id(1'b0, p, 0));
        chk_log("t2");
        chk("t2_dstart", 64'(log_q[0].ds), 64'h01);
        chk("t2_dend",   64'(log_q[0].de), 64'h80);
        chk("t2_dtmark", 64'(log_q[0].ts), 64'h00);
        chk("t2_tstart", 64'(log_q[4].ts), 64'h01);
        chk("t2_tend",   64'(log_q[5].te), 64'h80);

        // 3: trdy low for 5 cycles mid-TLP
        new_test();
        push_pkt(1'b1, 4, 4, 8'hFF, 8'h0F);
        cyc();
        cyc();
        trdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("t3_ready%0d", i), 64'(tlp_ready), 64'd0);
            chk($sformatf("t3_hold%0d", i),  data, {8{mk_id(1'b1, 4, 1)}});
            chk($sformatf("t3_irdy%0d", i),  64'(irdy), 64'd1);
            cyc();
        end
        trdy = 1'b1;
        drain("t3");
        for (int b = 0; b < 4; b++) exp_ids.push_back(mk_id(1'b1, 4, b));
        chk_log("t3");
        chk("t3_end", 64'(log_q[3].te), 64'h08);

        // 4: stall request during a 4-beat TLP
        new_test();
        push_pkt(1'b1, 5, 4, 8'hFF, 8'hFF);
        cyc();
        stall_req = 1'b1;
        repeat (3) cyc();
        chk("t4_ack_last", 64'(stall_ack), 64'd0);
        chk("t4_irdy_last", 64'(irdy), 64'd1);
        cyc();
        chk("t4_ack_set", 64'(stall_ack), 64'd1);
        chk("t4_irdy_empty", 64'(irdy), 64'd0);
        push_pkt(1'b1, 6, 1, 8'hFF, 8'hFF);
        #1;
        chk("t4_no_grant", 64'(tlp_ready), 64'd0);
        cyc();
        cyc();
        chk("t4_ack_held", 64'(stall_ack), 64'd1);
        chk("t4_no_grant2", 64'(tlp_ready), 64'd0);
        stall_req = 1'b0;
        cyc();
        chk("t4_ack_drop", 64'(stall_ack), 64'd0);
        chk("t4_regrant", 64'(tlp_ready), 64'd1);
        drain("t4");
        for (int b = 0; b < 4; b++) exp_ids.push_back(mk_id(1'b1, 5, b));
        exp_ids.push_back(mk_id(1'b1, 6, 0));
        chk_log("t4");

        // 5: link leaves ACTIVE at TLP beat 2 of 6
        new_test();
        push_pkt(1'b1, 7, 6, 8'hFF, 8'hFF);
        cyc();
        state_sts = 4'h0;
        #1;
        chk("t5_ready_off", 64'(tlp_ready), 64'd0);
        chk("t5_inflight", 64'(irdy), 64'd1);
        cyc();
        chk("t5_irdy_off", 64'(irdy), 64'd0);
        chk("t5_sink", 64'(tlp_ready), 64'd1);
        drain("t5");
        chk("t5_abort", 64'(abort_cnt), 64'd1);
        push_pkt(1'b1, 8, 1, 8'hFF, 8'hFF);
        #1;
        chk("t5_idle_gate", 64'(tlp_ready), 64'd0);
        cyc();
        chk("t5_idle_irdy", 64'(irdy), 64'd0);
        state_sts = 4'h1;
        drain("t5b");
        chk("t5_abort_keep", 64'(abort_cnt), 64'd1);
        exp_ids.push_back(mk_id(1'b1, 7, 0));
        exp_ids.push_back(mk_id(1'b1, 8, 0));
        chk_log("t5");

        // 6: reset mid-DLLP, then a fresh DLLP
        new_test();
        push_pkt(1'b0, 9, 3, 8'hFF, 8'hFF);
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        chk("t6_irdy",   64'(irdy),       64'd0);
        chk("t6_valid",  64'(valid),      64'd0);
        chk("t6_data",   data,            64'd0);
        chk("t6_dstart", 64'(dllp_start), 64'd0);
        chk("t6_dend",   64'(dllp_end),   64'd0);
        chk("t6_ack",    64'(stall_ack),  64'd0);
        chk("t6_abort",  64'(abort_cnt),  64'd0);
        chk("t6_dready", 64'(dllp_ready), 64'd0);
        reset = 1'b0;
        dllp_q.delete();
        push_pkt(1'b0, 10, 1, 8'h3C, 8'h3C);
        #1;
        chk("t6_grant", 64'(dllp_ready), 64'd1);
        drain("t6");
        exp_ids.push_back(mk_id(1'b0, 9, 0));
        exp_ids.push_back(mk_id(1'b0, 9, 1));
        exp_ids.push_back(mk_id(1'b0, 10, 0));
        chk_log("t6");
        chk("t6_fresh_start", 64'(log_q[2].ds), 64'h04);
        chk("t6_fresh_end",   64'(log_q[2].de), 64'h20);
        chk("t6_fresh_valid", 64'(log_q[2].v),  64'h3C);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
